jt6295_rom_sched: RTL and testbench

Round-robin ROM access scheduler for the JT6295 ADPCM engine. Shares one sample ROM port between a control requester (phrase-table/header reads) and four channel requesters (ADPCM nibble fetches). Each access is held until the ROM port reports a stable `rom_ok`, and each requester gets its own data register and ok flag. Sits between the channel/control logic and the external ROM interface, replacing fixed two-slot priority muxing.

---
 rtl/jt6295_rom_sched.sv | 123 ++++++++++++
 tb/tb_jt6295_rom_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/jt6295_rom_sched.sv
// jt6295_rom_sched: round-robin sharing of one sample ROM port between ctrl and four ADPCM channels
// Ctrl always wins; channels rotate from r_rr. Data is accepted after OKDLY+1 stable rom_ok samples.
module jt6295_rom_sched #(
    parameter int AW    = 18,
    parameter int OKDLY = 3,
    parameter int TOUT  = 255
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_ctrl_cs,
    input  logic [AW-1:0]   i_ctrl_addr,
    output logic [7:0]      o_ctrl_dout,
    output logic            o_ctrl_ok,
    input  logic [3:0]      i_ch_cs,
    input  logic [4*AW-1:0] i_ch_addr,
    output logic [31:0]     o_ch_dout,
    output logic [3:0]      o_ch_ok,
    output logic [AW-1:0]   o_rom_addr,
    output logic            o_rom_cs,
    input  logic [7:0]      i_rom_data,
    input  logic            i_rom_ok,
    output logic            o_busy,
    output logic            o_tout_err
);
    typedef enum logic {IDLE, WAIT} state_t;
    localparam int GW = OKDLY > 0 ? $clog2(OKDLY + 1) : 1;

    state_t        r_state, w_next;
    logic [1:0]    r_rr;
    logic [2:0]    r_win;
    logic [AW-1:0] r_addr;
    logic [GW-1:0] r_gcnt;
    logic [7:0]    r_tcnt;
    logic [4:0]    r_ok;
    logic [AW-1:0] r_last [5];
    logic [7:0]    r_dout [5];
    logic          r_tout_err;

    logic [4:0]    w_cs, w_elig;
    logic [AW-1:0] w_addr [5];
    logic [2:0]    w_sel;
    logic          w_grant, w_cap, w_tout, w_done, w_hit;

    // requester index 4 is ctrl, 0..3 are channels
    for (genvar n = 0; n < 4; n++) begin : g_ch
        assign w_cs[n]              = i_ch_cs[n];
        assign w_addr[n]            = i_ch_addr[AW*n +: AW];
        assign o_ch_dout[8*n +: 8]  = r_dout[n];
    end
    assign w_cs[4]   = i_ctrl_cs;
    assign w_addr[4] = i_ctrl_addr;

    // a held hit (ok with unchanged address) is never fetched again
    for (genvar n = 0; n < 5; n++) begin : g_elig
        assign w_elig[n] = w_cs[n] && !(r_ok[n] && w_addr[n] == r_last[n]);
    end

    always_comb begin
        w_sel = 3'd4;
        if (!w_elig[4])
            for (int k = 3; k >= 0; k--)
                if (w_elig[r_rr + 2'(k)]) w_sel = {1'b0, r_rr + 2'(k)};
    end

    assign w_grant = r_state == IDLE && |w_elig;
    assign w_cap   = r_state == WAIT && i_rom_ok && r_gcnt == GW'(OKDLY);
    assign w_tout  = r_state == WAIT && !w_cap && r_tcnt == 8'(TOUT);
    assign w_done  = w_cap || w_tout;
    assign w_hit   = w_cs[r_win] && w_addr[r_win] == r_addr;

    always_comb begin
        w_next = r_state;
        if (w_grant) w_next = WAIT;
        if (w_done)  w_next = IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_rr       <= '0;
            r_win      <= '0;
            r_addr     <= '0;
            r_gcnt     <= '0;
            r_tcnt     <= '0;
            r_ok       <= '0;
            r_tout_err <= 1'b0;
            for (int n = 0; n < 5; n++) begin
                r_last[n] <= '0;
                r_dout[n] <= '0;
            end
        end else begin
            r_state    <= w_next;
            r_tout_err <= w_tout;
            if (w_grant) begin
                r_addr <= w_addr[w_sel];
                r_win  <= w_sel;
                r_gcnt <= '0;
                r_tcnt <= '0;
            end else if (r_state == WAIT) begin
                r_tcnt <= r_tcnt + 8'd1;
                r_gcnt <= !i_rom_ok ? '0 : r_gcnt == GW'(OKDLY) ? r_gcnt : r_gcnt + 1'b1;
            end
            if (w_done && !r_win[2]) r_rr <= r_win[1:0] + 2'd1;
            for (int n = 0; n < 5; n++) begin
                if (w_done && r_win == 3'(n)) begin
                    if (w_hit || w_tout) r_dout[n] <= w_cap ? i_rom_data : 8'h00;
                    if (w_hit) r_last[n] <= r_addr;
                    r_ok[n] <= w_hit;
                end else if ((w_grant && w_sel == 3'(n)) || !w_cs[n] || w_addr[n] != r_last[n]) begin
                    r_ok[n] <= 1'b0;
                end
            end
        end
    end

    assign o_busy      = r_state == WAIT;
    assign o_rom_cs    = o_busy;
    assign o_rom_addr  = r_addr;
    assign o_ctrl_dout = r_dout[4];
    assign o_ctrl_ok   = r_ok[4];
    assign o_ch_ok     = r_ok[3:0];
    assign o_tout_err  = r_tout_err;
endmodule

// File: tb/tb_jt6295_rom_sched.sv
// tb_jt6295_rom_sched: directed checks of grant order, stability filter, discard, timeout and reset
// ROM model returns addr[7:0]+0x37 so each fetch has a distinct, hand-computable byte.
module tb_jt6295_rom_sched;
    localparam int AW = 18;

    logic            clk = 1'b0, rst_n = 1'b0, ctrl_cs = 1'b0, rom_ok = 1'b0;
    logic [AW-1:0]   ctrl_addr = '0;
    logic [3:0]      ch_cs = '0;
    logic [4*AW-1:0] ch_addr = '0;
    logic [7:0]      ctrl_dout, rom_data;
    logic            ctrl_ok, rom_cs, busy, tout_err;
    logic [31:0]     ch_dout;
    logic [3:0]      ch_ok;
    logic [AW-1:0]   rom_addr;
    int              errors = 0, checks = 0;

    always #5 clk = ~clk;
    assign rom_data = rom_addr[7:0] + 8'h37;

    jt6295_rom_sched #(.AW(AW), .OKDLY(3), .TOUT(255)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ctrl_cs(ctrl_cs), .i_ctrl_addr(ctrl_addr), .o_ctrl_dout(ctrl_dout), .o_ctrl_ok(ctrl_ok),
        .i_ch_cs(ch_cs), .i_ch_addr(ch_addr), .o_ch_dout(ch_dout), .o_ch_ok(ch_ok),
        .o_rom_addr(rom_addr), .o_rom_cs(rom_cs), .i_rom_data(rom_data), .i_rom_ok(rom_ok),
        .o_busy(busy), .o_tout_err(tout_err)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_addr(input int n, input logic [AW-1:0] a);
        ch_addr[AW*n +: AW] = a;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        step(2);
        chk("rst_rom_cs", 32'(rom_cs), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ch_ok", 32'(ch_ok), 0);
        chk("rst_ctrl_ok", 32'(ctrl_ok), 0);
        chk("rst_tout", 32'(tout_err), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_ch_dout", ch_dout, 0);
        rst_n = 1'b1;
        step(1);
        chk("idle_rom_cs", 32'(rom_cs), 0);
        // single channel fetch
        set_addr(0, 18'h00123); ch_cs = 4'b0001; rom_ok = 1'b1;
        step(1);
        chk("single_addr", 32'(rom_addr), 32'h123);
        chk("single_cs", 32'(rom_cs), 1);
        chk("single_busy", 32'(busy), 1);
        step(3);
        chk("single_ok_early", 32'(ch_ok), 0);
        step(1);
        chk("single_ok", 32'(ch_ok), 32'b0001);
        chk("single_dout", 32'(ch_dout[7:0]), 32'h5A);
        chk("single_cs_drop", 32'(rom_cs), 0);
        step(3);
        chk("single_no_refetch", 32'(rom_cs), 0);
        chk("single_held", 32'(ch_ok), 32'b0001);
        // reset between tests clears ok and rr
        rst_n = 1'b0; ch_cs = '0;
        step(1);
        chk("rst2_ch_ok", 32'(ch_ok), 0);
        chk("rst2_dout", ch_dout, 0);
        // ctrl priority then round-robin 0,1,2,3,0
        rst_n = 1'b1; ctrl_cs = 1'b1; ctrl_addr = 18'h3F000; ch_cs = 4'hF;
        set_addr(0, 18'h200); set_addr(1, 18'h210); set_addr(2, 18'h220); set_addr(3, 18'h230);
        step(1);
        chk("ctrl_first_addr", 32'(rom_addr), 32'h3F000);
        step(4);
        chk("ctrl_ok", 32'(ctrl_ok), 1);
        chk("ctrl_dout", 32'(ctrl_dout), 32'h37);
        chk("ctrl_ch_ok", 32'(ch_ok), 0);
        step(1);
        chk("rr_ch0_addr", 32'(rom_addr), 32'h200);
        step(4);
        chk("rr_ch0_ok", 32'(ch_ok), 32'b0001);
        chk("rr_ch0_dout", 32'(ch_dout[7:0]), 32'h37);
        set_addr(0, 18'h240);
        step(1);
        chk("rr_ch1_addr", 32'(rom_addr), 32'h210);
        chk("rr_ch0_cleared", 32'(ch_ok), 0);
        chk("ctrl_held", 32'(ctrl_ok), 1);
        step(3);
        chk("rr_ch1_early", 32'(ch_ok), 0);
        step(1);
        chk("rr_ch1_ok", 32'(ch_ok), 32'b0010);
        chk("rr_ch1_dout", 32'(ch_dout[15:8]), 32'h47);
        step(1);
        chk("rr_ch2_addr", 32'(rom_addr), 32'h220);
        step(4);
        chk("rr_ch2_ok", 32'(ch_ok), 32'b0110);
        chk("rr_ch2_dout", 32'(ch_dout[23:16]), 32'h57);
        step(1);
        chk("rr_ch3_addr", 32'(rom_addr), 32'h230);
        step(4);
        chk("rr_ch3_ok", 32'(ch_ok), 32'b1110);
        chk("rr_ch3_dout", 32'(ch_dout[31:24]), 32'h67);
        step(1);
        chk("rr_ch0b_addr", 32'(rom_addr), 32'h240);
        step(4);
        chk("rr_ch0b_ok", 32'(ch_ok), 32'b1111);
        chk("rr_ch0b_dout", 32'(ch_dout[7:0]), 32'h77);
        // rom_ok glitch in cycle 3 delays capture by 3 cycles
        set_addr(1, 18'h150);
        step(1);
        chk("glitch_addr", 32'(rom_addr), 32'h150);
        step(2);
        rom_ok = 1'b0;
        step(1);
        rom_ok = 1'b1;
        step(1);
        chk("glitch_nominal", 32'(ch_ok[1]), 0);
        step(2);
        chk("glitch_late", 32'(ch_ok[1]), 0);
        step(1);
        chk("glitch_ok", 32'(ch_ok[1]), 1);
        chk("glitch_dout", 32'(ch_dout[15:8]), 32'h87);
        // address change mid-access discards data, then refetches
        set_addr(2, 18'h160);
        step(1);
        chk("chg_addr", 32'(rom_addr), 32'h160);
        step(1);
        set_addr(2, 18'h170);
        step(3);
        chk("chg_idle", 32'(busy), 0);
        chk("chg_ok", 32'(ch_ok[2]), 0);
        chk("chg_dout_kept", 32'(ch_dout[23:16]), 32'h57);
        step(1);
        chk("chg_reissue", 32'(rom_addr), 32'h170);
        chk("chg_busy", 32'(busy), 1);
        step(4);
        chk("chg_ok2", 32'(ch_ok[2]), 1);
        chk("chg_dout", 32'(ch_dout[23:16]), 32'hA7);
        // timeout with rom_ok stuck low
        rom_ok = 1'b0; set_addr(3, 18'h180);
        step(1);
        chk("to_addr", 32'(rom_addr), 32'h180);
        step(255);
        chk("to_not_yet", 32'(tout_err), 0);
        chk("to_busy", 32'(busy), 1);
        step(1);
        chk("to_pulse", 32'(tout_err), 1);
        chk("to_ok", 32'(ch_ok), 32'b1111);
        chk("to_dout", 32'(ch_dout[31:24]), 0);
        chk("to_idle", 32'(busy), 0);
        step(1);
        chk("to_pulse_end", 32'(tout_err), 0);
        // async reset mid-access, rr returns to 0
        rom_ok = 1'b1; set_addr(1, 18'h190); set_addr(3, 18'h1B0);
        step(1);
        chk("pre_rst_ch1_addr", 32'(rom_addr), 32'h190);
        step(4);
        chk("pre_rst_ch1_ok", 32'(ch_ok[1]), 1);
        chk("pre_rst_ch1_dout", 32'(ch_dout[15:8]), 32'hC7);
        step(1);
        chk("pre_rst_ch3_addr", 32'(rom_addr), 32'h1B0);
        step(1);
        #2 rst_n = 1'b0; ctrl_cs = 1'b0;
        #1;
        chk("arst_rom_cs", 32'(rom_cs), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ch_ok", 32'(ch_ok), 0);
        chk("arst_ctrl_ok", 32'(ctrl_ok), 0);
        step(1);
        rst_n = 1'b1;
        step(1);
        chk("post_rst_grant", 32'(rom_addr), 32'h240);
        chk("post_rst_busy", 32'(busy), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
